// File: rtl/phys_reg_file_if.sv
// Bundle of the allocation, writeback and read-port signals of the
// multi-ported physical register file. The master side is the core
// (rename/dispatch, CDB, reservation stations); the slave side is the file.
interface phys_reg_file_if #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int NUM_WB    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_RD    = 4
);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic                                flush;
  logic [NUM_ALLOC-1:0]                alloc_en;
  logic [NUM_ALLOC-1:0][PREG_W-1:0]    alloc_preg;
  logic [NUM_WB-1:0]                   wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0]       wb_preg;
  logic [NUM_WB-1:0][DATA_W-1:0]       wb_data;
  logic [NUM_RD-1:0]                   rd_en;
  logic [NUM_RD-1:0][PREG_W-1:0]       rd_preg;
  logic [NUM_RD-1:0]                   rd_valid;
  logic [NUM_RD-1:0][DATA_W-1:0]       rd_data;
  logic [NUM_RD-1:0]                   rd_ready;
  logic [NUM_PREGS-1:0]                ready_vec;
  logic                                err_multi_write;

  modport master (
    output flush, alloc_en, alloc_preg, wb_valid, wb_preg, wb_data, rd_en, rd_preg,
    input  rd_valid, rd_data, rd_ready, ready_vec, err_multi_write
  );

  modport slave (
    input  flush, alloc_en, alloc_preg, wb_valid, wb_preg, wb_data, rd_en, rd_preg,
    output rd_valid, rd_data, rd_ready, ready_vec, err_multi_write
  );
endinterface

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with per-register ready bits,
// N-way CDB writeback (lowest port wins), dispatch allocation, flush
// recovery, same-cycle writeback-to-read bypass and an optional registered
// read stage. p0 is hardwired to zero and always ready.
module phys_reg_file_mp #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int NUM_WB    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_RD    = 4,
  parameter bit REG_RD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  phys_reg_file_if.slave    prf
);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic [DATA_W-1:0]    data_q [NUM_PREGS];
  logic [DATA_W-1:0]    data_d [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q, ready_d;
  logic                 err_q, err_d;

  logic [NUM_RD-1:0]              rd_valid_d;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_d;
  logic [NUM_RD-1:0]              rd_ready_d;

  // Next state of storage, ready bits and the sticky multi-write error.
  // Later assignments override earlier ones, which encodes the priority
  // flush > alloc > writeback for ready and lowest-port-wins for data.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    data_d  = data_q;
    ready_d = ready_q;
    err_d   = err_q;

    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (prf.wb_valid[k] && prf.wb_preg[k] != '0) begin
        data_d[prf.wb_preg[k]]  = prf.wb_data[k];
        ready_d[prf.wb_preg[k]] = 1'b1;
      end
    end

    for (int i = 0; i < NUM_WB; i++) begin
      for (int j = i + 1; j < NUM_WB; j++) begin
        if (prf.wb_valid[i] && prf.wb_valid[j] &&
            prf.wb_preg[i] == prf.wb_preg[j] && prf.wb_preg[i] != '0)
          err_d = 1'b1;
      end
    end

    for (int k = 0; k < NUM_ALLOC; k++) begin
      if (prf.alloc_en[k] && prf.alloc_preg[k] != '0)
        ready_d[prf.alloc_preg[k]] = 1'b0;
    end

    if (prf.flush)
      ready_d = '1;

    data_d[0]  = '0;
    ready_d[0] = 1'b1;
  end

  // Storage, ready and error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge; the comb block above uses blocking ones.
    if (!rst) begin
      // NOTE: the data array is reset on purpose: a cleared file is
      // architecturally visible after reset (reads return 0).
      data_q  <= '{default: '0};
      ready_q <= '1;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Read ports: stored value and ready bit, overridden by the lowest
  // matching writeback port. Reads see pre-edge ready, so alloc is ignored.
  always_comb begin
    rd_valid_d = prf.rd_en;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data_d[r]  = data_q[prf.rd_preg[r]];
      rd_ready_d[r] = ready_q[prf.rd_preg[r]];
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (prf.wb_valid[k] && prf.wb_preg[k] == prf.rd_preg[r] &&
            prf.rd_preg[r] != '0) begin
          rd_data_d[r]  = prf.wb_data[k];
          rd_ready_d[r] = 1'b1;
        end
      end
    end
  end

  generate
    if (REG_RD) begin : g_reg_rd
      logic [NUM_RD-1:0]              rd_valid_q;
      logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_q;
      logic [NUM_RD-1:0]              rd_ready_q;

      // One-cycle read stage; reset aborts any read in flight.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_valid_q <= '0;
          rd_data_q  <= '0;
          rd_ready_q <= '0;
        end else begin
          rd_valid_q <= rd_valid_d;
          rd_data_q  <= rd_data_d;
          rd_ready_q <= rd_ready_d;
        end
      end

      assign prf.rd_valid = rd_valid_q;
      assign prf.rd_data  = rd_data_q;
      assign prf.rd_ready = rd_ready_q;
    end else begin : g_comb_rd
      assign prf.rd_valid = rd_valid_d;
      assign prf.rd_data  = rd_data_d;
      assign prf.rd_ready = rd_ready_d;
    end
  endgenerate

  assign prf.ready_vec       = ready_q;
  assign prf.err_multi_write = err_q;
endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Directed bench for phys_reg_file_mp. Two instances share the same
// stimulus: one with a registered read stage, one with combinational reads.
module tb_phys_reg_file_mp;
  localparam logic [63:0] ALL_RDY = {64{1'b1}};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  phys_reg_file_if bus   ();
  phys_reg_file_if bus_c ();

  assign bus_c.flush      = bus.flush;
  assign bus_c.alloc_en   = bus.alloc_en;
  assign bus_c.alloc_preg = bus.alloc_preg;
  assign bus_c.wb_valid   = bus.wb_valid;
  assign bus_c.wb_preg    = bus.wb_preg;
  assign bus_c.wb_data    = bus.wb_data;
  assign bus_c.rd_en      = bus.rd_en;
  assign bus_c.rd_preg    = bus.rd_preg;

  phys_reg_file_mp #(.REG_RD(1'b1)) u_reg  (.clk(clk), .rst(rst), .prf(bus));
  phys_reg_file_mp #(.REG_RD(1'b0)) u_comb (.clk(clk), .rst(rst), .prf(bus_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.alloc_en   = '0;
    bus.alloc_preg = '0;
    bus.wb_valid   = '0;
    bus.wb_preg    = '0;
    bus.wb_data    = '0;
    bus.rd_en      = '0;
    bus.rd_preg    = '0;
  endtask

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
    check("rst_ready_vec", bus.ready_vec, ALL_RDY);
    check("rst_err", bus.err_multi_write, 0);
    check("rst_rd_valid_reg", bus.rd_valid, 0);

    // Read p5 after reset.
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd5;
    #1;
    check("p5_comb_data", bus_c.rd_data[0], 0);
    check("p5_comb_ready", bus_c.rd_ready[0], 1);
    check("p5_comb_valid", bus_c.rd_valid, 4'b0001);
    step();
    check("p5_reg_valid", bus.rd_valid, 4'b0001);
    check("p5_reg_data", bus.rd_data[0], 0);
    check("p5_reg_ready", bus.rd_ready[0], 1);

    // Alloc p7 in t, WB p7 in t+2.
    idle();
    bus.alloc_en[0] = 1'b1; bus.alloc_preg[0] = 6'd7;
    step();
    idle();
    check("alloc_rv7_t1", bus.ready_vec[7], 0);
    bus.rd_en[2] = 1'b1; bus.rd_preg[2] = 6'd7;
    #1;
    check("alloc_comb_ready7", bus_c.rd_ready[2], 0);
    step();
    idle();
    check("alloc_rv7_t2", bus.ready_vec[7], 0);
    check("alloc_reg_ready7", bus.rd_ready[2], 0);
    bus.wb_valid[0] = 1'b1; bus.wb_preg[0] = 6'd7; bus.wb_data[0] = 32'hDEADBEEF;
    bus.rd_en[1] = 1'b1; bus.rd_preg[1] = 6'd7;
    #1;
    check("byp_comb_data7", bus_c.rd_data[1], 64'hDEADBEEF);
    check("byp_comb_ready7", bus_c.rd_ready[1], 1);
    step();
    idle();
    check("wb_rv7_t3", bus.ready_vec[7], 1);
    check("byp_reg_valid", bus.rd_valid, 4'b0010);
    check("byp_reg_data7", bus.rd_data[1], 64'hDEADBEEF);
    check("byp_reg_ready7", bus.rd_ready[1], 1);
    bus.rd_en[3] = 1'b1; bus.rd_preg[3] = 6'd7;
    #1;
    check("stored_comb_data7", bus_c.rd_data[3], 64'hDEADBEEF);
    step();

    // p0 protection: two WBs and an alloc on p0.
    idle();
    bus.wb_valid = 2'b11;
    bus.wb_preg[0] = 6'd0; bus.wb_data[0] = 32'hFFFFFFFF;
    bus.wb_preg[1] = 6'd0; bus.wb_data[1] = 32'hFFFFFFFF;
    bus.alloc_en[1] = 1'b1; bus.alloc_preg[1] = 6'd0;
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd0;
    #1;
    check("p0_comb_data_byp", bus_c.rd_data[0], 0);
    check("p0_comb_ready_byp", bus_c.rd_ready[0], 1);
    step();
    idle();
    check("p0_err", bus.err_multi_write, 0);
    check("p0_rv0", bus.ready_vec[0], 1);
    check("p0_reg_data", bus.rd_data[0], 0);
    check("p0_reg_ready", bus.rd_ready[0], 1);
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd0;
    #1;
    check("p0_comb_data", bus_c.rd_data[0], 0);
    step();

    // Alloc + WB collision on p3, then the same with flush (alloc p10 too).
    idle();
    bus.alloc_en[0] = 1'b1; bus.alloc_preg[0] = 6'd3;
    bus.wb_valid[1] = 1'b1; bus.wb_preg[1] = 6'd3; bus.wb_data[1] = 32'h55;
    step();
    idle();
    check("coll_rv3", bus.ready_vec[3], 0);
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd3;
    #1;
    check("coll_data3", bus_c.rd_data[0], 64'h55);
    check("coll_ready3", bus_c.rd_ready[0], 0);
    step();
    idle();
    bus.flush = 1'b1;
    bus.alloc_en = 2'b11; bus.alloc_preg[0] = 6'd3; bus.alloc_preg[1] = 6'd10;
    bus.wb_valid[0] = 1'b1; bus.wb_preg[0] = 6'd3; bus.wb_data[0] = 32'h66;
    step();
    idle();
    check("flush_ready_vec", bus.ready_vec, ALL_RDY);
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd3;
    #1;
    check("flush_data3", bus_c.rd_data[0], 64'h66);
    step();

    // Dual WB conflict on p9, plus a WB to p4 for the reset test.
    idle();
    bus.wb_valid = 2'b11;
    bus.wb_preg[0] = 6'd9; bus.wb_data[0] = 32'h11;
    bus.wb_preg[1] = 6'd9; bus.wb_data[1] = 32'h22;
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd9;
    #1;
    check("dual_byp_data9", bus_c.rd_data[0], 64'h11);
    step();
    idle();
    check("dual_err", bus.err_multi_write, 1);
    check("dual_err_comb_inst", bus_c.err_multi_write, 1);
    check("dual_reg_data9", bus.rd_data[0], 64'h11);
    bus.wb_valid[1] = 1'b1; bus.wb_preg[1] = 6'd4; bus.wb_data[1] = 32'hCAFE;
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd9;
    #1;
    check("dual_stored_data9", bus_c.rd_data[0], 64'h11);
    step();
    idle();
    check("dual_err_sticky", bus.err_multi_write, 1);

    // Reset mid-read of p4 (which now holds 0xCAFE).
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd4;
    #1;
    check("pre_rst_data4", bus_c.rd_data[0], 64'hCAFE);
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle();
    check("rst_mid_valid", bus.rd_valid, 0);
    check("rst_mid_data", bus.rd_data[0], 0);
    check("rst_mid_err", bus.err_multi_write, 0);
    check("rst_mid_ready_vec", bus.ready_vec, ALL_RDY);
    bus.rd_en[0] = 1'b1; bus.rd_preg[0] = 6'd4;
    #1;
    check("rst_cleared_data4", bus_c.rd_data[0], 0);
    step();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/phys_reg_file_mp.md
# phys_reg_file_mp

Multi-ported physical register file with per-register ready (scoreboard) bits, N-way CDB writeback, dispatch-time allocation, same-cycle write-to-read bypass and an optional registered read stage. It is the next generation of the out-of-order core's physical register file and sits between rename/dispatch (allocation), the CDB (writeback) and the reservation stations and functional units (operand reads). Flush recovery and multi-write error detection are built in.

## Interface
- NUM_PREGS, 64, number of physical registers; p0 is hardwired zero. PREG_W = $clog2(NUM_PREGS)
- DATA_W, 32, register data width
- NUM_WB, 2, CDB writeback ports
- NUM_ALLOC, 2, allocation ports (superscalar dispatch width)
- NUM_RD, 4, read ports
- REG_RD, 1, 0 = combinational read, 1 = one-cycle registered read
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- flush  input  1  pipeline flush; marks all registers ready
- alloc_en  input  [NUM_ALLOC]  allocate preg (clear ready)
- alloc_preg  input  [NUM_ALLOC][PREG_W]  preg being allocated
- wb_valid  input  [NUM_WB]  CDB writeback valid
- wb_preg  input  [NUM_WB][PREG_W]  writeback destination
- wb_data  input  [NUM_WB][DATA_W]  writeback value
- rd_en  input  [NUM_RD]  read request
- rd_preg  input  [NUM_RD][PREG_W]  preg to read
- rd_valid  output  [NUM_RD]  read result valid
- rd_data  output  [NUM_RD][DATA_W]  read value
- rd_ready  output  [NUM_RD]  ready bit of the read preg
- ready_vec  output  [NUM_PREGS]  registered ready bits, for reservation-station wakeup
- err_multi_write  output  1  sticky: two WB ports targeted the same nonzero preg in the same cycle

## Operation
- State: data[NUM_PREGS], ready[NUM_PREGS], err flag.
- p0: data always 0, ready always 1; alloc and WB targeting p0 are ignored, and reads of p0 return 0 with ready 1.
- Alloc: alloc_en[k] clears ready[alloc_preg[k]] at the next edge. Data is untouched.
- WB: wb_valid[k] writes data[wb_preg[k]] = wb_data[k] and sets ready.
- WB on the same preg from multiple ports: the lowest-index port wins, and err_multi_write is set (sticky until reset).
- Alloc and WB on the same preg in the same cycle: data takes the WB value; ready ends 0 (alloc wins).
- Flush: all ready bits become 1 at the next edge, overriding any same-cycle alloc. Same-cycle WB data is still written.
- Read with bypass: if any wb_valid[k] matches rd_preg (nonzero), rd_data = wb_data of the lowest matching k and rd_ready = 1. Otherwise the stored data and ready bit are returned.
- Same-cycle alloc does not affect reads: reads see pre-edge ready.
- rd_en = 0: rd_data and rd_ready are don't-care; rd_valid = 0.
- REG_RD = 0: outputs are combinational from the current inputs and state; rd_valid = rd_en.
- REG_RD = 1: rd_data and rd_ready are captured, with bypass, at the edge ending the request cycle and are presented the next cycle; rd_valid is rd_en delayed one cycle. The registered result is not updated by later writebacks.

## Timing
- Reset (rst = 0 at an edge): data all 0, ready all 1, err_multi_write 0, rd_valid 0, registered rd_data and rd_ready 0. Reset overrides flush, alloc and WB in that cycle and aborts any in-flight registered read.
- WB latency: the written value is visible through bypass in the same cycle and from storage from the next cycle.
- ready_vec reflects post-edge state: an allocation in cycle t shows ready_vec = 0 in t+1.
- Read latency: 0 cycles (REG_RD = 0) or 1 cycle (REG_RD = 1). All read ports are independent, with no stalls or back-pressure.
- Priority at one edge for a given preg: reset > flush (ready) > alloc (ready) > WB (ready).

## Test plan
- Reset then read: hold rst = 0 for 2 cycles, release, read p5 -> rd_data = 0, rd_ready = 1, ready_vec all 1, err_multi_write = 0.
- Alloc then WB: alloc p7 in t, then WB p7 = 0xDEADBEEF in t+2 -> ready_vec[7] = 0 in t+1 and t+2, and 1 in t+3. A read of p7 in t+2 returns 0xDEADBEEF with ready 1 via bypass (REG_RD = 0), or the same in t+3 (REG_RD = 1).
- Dual WB conflict: WB0 p9 = 0x11 and WB1 p9 = 0x22 in the same cycle -> data[9] = 0x11, err_multi_write = 1 and stays 1 until reset.
- Alloc/WB/flush collision: alloc p3 with WB p3 = 0x55 -> ready[3] = 0, data 0x55. The same stimulus with flush = 1 -> ready[3] = 1, data 0x55.
- p0 protection: WB p0 = 0xFFFFFFFF plus alloc p0 -> a read of p0 returns 0 with ready 1, and err stays 0 even if two ports write p0.
- Reset mid-read (REG_RD = 1): rd_en on p4 at t with rst = 0 at the t edge -> rd_valid = 0 in t+1 and no stale data is presented.
